// File: rtl/alu_trace_fifo.sv
// alu_trace_fifo: captures changed ALU results into a small FWFT circular FIFO for a trace consumer.
// Latency: a sample pushed at edge N is visible (out_valid=1) after edge N; no empty bypass.
// Backpressure: out_ready=0 holds the head; when full, new samples are dropped and counted (saturating).
module alu_trace_fifo #(
  parameter int word_width = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3,
  parameter int OVF_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] ALU_out,
  input  logic                  capture_en,
  input  logic                  clear,
  output logic [word_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PTR_W:0]        count,
  output logic                  full,
  output logic [OVF_W-1:0]      drop_cnt
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OVF_W-1:0] OVF_ONE  = OVF_W'(1);

  logic [word_width-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [OVF_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic                  last_valid_q, last_valid_d;
  logic [word_width-1:0] last_value_q, last_value_d;

  logic new_sample;
  logic pop;
  logic accept;
  logic drop;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign drop_cnt  = drop_cnt_q;
  // Empty FIFO presents zero so the reset/empty view of out_data is deterministic
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // Change detection, push/pop arbitration and next-state for pointers, occupancy and drop counter
  always_comb begin
    new_sample   = capture_en && (!last_valid_q || (ALU_out != last_value_q));
    pop          = out_valid && out_ready;
    // A pop in the same edge frees a slot, so a full FIFO can still accept
    accept       = new_sample && (!full || pop);
    drop         = new_sample && full && !pop;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_cnt_d   = drop_cnt_q;
    last_valid_d = last_valid_q;
    last_value_d = last_value_q;

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      drop_cnt_d   = '0;
      last_valid_d = 1'b0;
    end else begin
      if (capture_en) begin
        last_value_d = ALU_out;
        last_valid_d = 1'b1;
      end
      if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (accept && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !accept) count_d = count_q - CNT_ONE;
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + OVF_ONE;
    end
  end

  // Control state registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_cnt_q   <= '0;
      last_valid_q <= 1'b0;
      last_value_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_cnt_q   <= drop_cnt_d;
      last_valid_q <= last_valid_d;
      last_value_q <= last_value_d;
    end
  end

  // Storage write; contents are don't-care until a pointer exposes them, so no reset
  always_ff @(posedge clk) begin
    if (accept && !clear) mem_q[wr_ptr_q] <= ALU_out;
  end

endmodule

// File: tb/tb_alu_trace_fifo.sv
module tb_alu_trace_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] ALU_out;
  logic        capture_en;
  logic        clear;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        full;
  logic [3:0]  drop_cnt;

  int n_checks;
  int n_pass;

  alu_trace_fifo #(
    .word_width(32), .DEPTH(8), .PTR_W(3), .OVF_W(4)
  ) dut (
    .clk(clk), .rst(rst), .ALU_out(ALU_out), .capture_en(capture_en),
    .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .full(full), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // advance one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pop one entry, checking it is the expected head
  task automatic pop_expect(input logic [31:0] v);
    chk("drain_valid", {31'b0, out_valid}, 32'd1);
    chk("drain_data", out_data, v);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b0; ALU_out = '0; capture_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_count", {28'b0, count}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_drop", {28'b0, drop_cnt}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    step(); step();
    rst = 1'b1;
    step();

    // 1: repeated value captured once, then the change
    capture_en = 1'b1; ALU_out = 32'h5;
    repeat (4) step();
    ALU_out = 32'h9;
    step();
    capture_en = 1'b0;
    chk("t1_count", {28'b0, count}, 32'd2);
    chk("t1_head", out_data, 32'h5);
    pop_expect(32'h5);
    pop_expect(32'h9);
    chk("t1_empty", {31'b0, out_valid}, 32'd0);

    // 2: fill to full, two extra samples dropped
    capture_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      ALU_out = 32'(i);
      if (i == 1) begin
        // no empty bypass: valid stays low until the push edge
        chk("t2_nobypass", {31'b0, out_valid}, 32'd0);
      end
      step();
      if (i == 1) chk("t2_first_vis", {31'b0, out_valid}, 32'd1);
    end
    chk("t2_full", {31'b0, full}, 32'd1);
    chk("t2_count", {28'b0, count}, 32'd8);
    chk("t2_drop", {28'b0, drop_cnt}, 32'd2);

    // 3: push onto a full FIFO while popping is accepted
    ALU_out = 32'h20; out_ready = 1'b1;
    chk("t3_head", out_data, 32'h1);
    step();
    out_ready = 1'b0; capture_en = 1'b0;
    chk("t3_count", {28'b0, count}, 32'd8);
    chk("t3_drop", {28'b0, drop_cnt}, 32'd2);
    chk("t3_head_hold", out_data, 32'h2);
    step();
    chk("t3_hold_noready", out_data, 32'h2);
    for (int i = 2; i <= 8; i++) pop_expect(32'(i));
    pop_expect(32'h20);
    chk("t3_empty", {31'b0, out_valid}, 32'd0);

    // clear before streaming so the drop counter starts from zero
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_drop", {28'b0, drop_cnt}, 32'd0);

    // 4: streaming with the consumer always ready
    capture_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ALU_out = 32'h100 + 32'(i);
      step();
      chk("t4_data", out_data, 32'h100 + 32'(i));
      chk("t4_count", {28'b0, count}, 32'd1);
    end
    capture_en = 1'b0;
    step();
    out_ready = 1'b0;
    chk("t4_empty", {28'b0, count}, 32'd0);
    chk("t4_drop", {28'b0, drop_cnt}, 32'd0);

    // 5: saturate the 4-bit drop counter, then clear
    capture_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ALU_out = 32'h200 + 32'(i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      ALU_out = 32'h300 + 32'(i);
      step();
    end
    chk("t5_sat", {28'b0, drop_cnt}, 32'hF);
    ALU_out = 32'h3FF;
    step();
    chk("t5_sat_hold", {28'b0, drop_cnt}, 32'hF);
    chk("t5_head", out_data, 32'h200);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t5_clr_count", {28'b0, count}, 32'd0);
    chk("t5_clr_drop", {28'b0, drop_cnt}, 32'd0);
    chk("t5_clr_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("t5_recapture_cnt", {28'b0, count}, 32'd1);
    chk("t5_recapture_dat", out_data, 32'h3FF);
    step();
    chk("t5_dedup", {28'b0, count}, 32'd1);

    // 6: asynchronous reset mid-cycle with buffered entries
    ALU_out = 32'hA1; step();
    ALU_out = 32'hA2; step();
    capture_en = 1'b0;
    chk("t6_count", {28'b0, count}, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_async_count", {28'b0, count}, 32'd0);
    chk("t6_async_drop", {28'b0, drop_cnt}, 32'd0);
    chk("t6_async_data", out_data, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("t6_post_valid", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
